// File: rtl/mcu_bus_if.sv
// MCU static-memory bus front end: synchronises nCS/nWE/nRD, latches one access,
// presents the page code to the chip-select decoder and issues aligned strobes.
module mcu_bus_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mcu_ncs,
  input  logic                  mcu_nwe,
  input  logic                  mcu_nrd,
  input  logic [ADDR_WIDTH-1:0] mcu_addr,
  input  logic [DATA_WIDTH-1:0] mcu_data_in,
  output logic [DATA_WIDTH-1:0] mcu_data_out,
  output logic                  mcu_data_oe,
  output logic [4:0]            buffer_address,
  output logic [7:0]            local_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_strobe,
  output logic                  rd_strobe,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  rd_timeout,
  output logic [2:0]            dbg_state_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] STROBE  = 3'd2;
  localparam logic [2:0] WAIT_RD = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;

  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

  logic [1:0]            ncs_sync_q, nwe_sync_q, nrd_sync_q;
  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  is_rd_q, is_rd_d;
  logic [4:0]            ba_q, ba_d;
  logic [7:0]            la_q, la_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic                  wr_stb_q, wr_stb_d;
  logic                  rd_stb_q, rd_stb_d;
  logic                  to_q, to_d;

  logic ncs_s, nwe_s, nrd_s, access_wr, access_rd;

  assign ncs_s = ncs_sync_q[1];
  assign nwe_s = nwe_sync_q[1];
  assign nrd_s = nrd_sync_q[1];
  // Both strobes low at once is not a legal access and matches neither term.
  assign access_wr = ~ncs_s & ~nwe_s & nrd_s;
  assign access_rd = ~ncs_s & ~nrd_s & nwe_s;

  function automatic logic [4:0] page_decode(input logic [4:0] page);
    case (page)
      5'h01:   page_decode = 5'd1;
      5'h02:   page_decode = 5'd2;
      5'h03:   page_decode = 5'd3;
      5'h08:   page_decode = 5'd4;
      5'h09:   page_decode = 5'd5;
      5'h0A:   page_decode = 5'd6;
      5'h0B:   page_decode = 5'd7;
      5'h10:   page_decode = 5'd8;
      default: page_decode = 5'd0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_rd_d  = is_rd_q;
    ba_d     = ba_q;
    la_d     = la_q;
    wd_d     = wd_q;
    dout_d   = dout_q;
    wr_stb_d = 1'b0;
    rd_stb_d = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        ba_d = 5'd0;
        if (access_wr || access_rd) begin
          la_d    = mcu_addr[7:0];
          ba_d    = page_decode(mcu_addr[12:8]);
          is_rd_d = access_rd;
          if (access_wr) wd_d = mcu_data_in;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // Strobe is registered on entry to STROBE so it lines up with the decoded chip select.
        wr_stb_d = ~is_rd_q;
        rd_stb_d = is_rd_q;
        state_d  = STROBE;
      end
      STROBE: begin
        if (is_rd_q) begin
          cnt_d   = '0;
          state_d = WAIT_RD;
        end else begin
          state_d = HOLD;
        end
      end
      WAIT_RD: begin
        if (ncs_s) begin
          ba_d    = 5'd0;
          state_d = IDLE;
        end else if (rd_valid) begin
          dout_d  = rd_data;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          dout_d  = '0;
          to_d    = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (ncs_s && nwe_s && nrd_s) begin
          ba_d    = 5'd0;
          state_d = IDLE;
        end
      end
      default: begin
        ba_d    = 5'd0;
        state_d = IDLE;
      end
    endcase
    oe_d = is_rd_q & ~nrd_s & (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_sync_q <= 2'b11;
      nwe_sync_q <= 2'b11;
      nrd_sync_q <= 2'b11;
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_rd_q    <= 1'b0;
      ba_q       <= 5'd0;
      la_q       <= 8'd0;
      wd_q       <= '0;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      ncs_sync_q <= {ncs_sync_q[0], mcu_ncs};
      nwe_sync_q <= {nwe_sync_q[0], mcu_nwe};
      nrd_sync_q <= {nrd_sync_q[0], mcu_nrd};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_rd_q    <= is_rd_d;
      ba_q       <= ba_d;
      la_q       <= la_d;
      wd_q       <= wd_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
      to_q       <= to_d;
    end
  end

  assign mcu_data_out   = dout_q;
  assign mcu_data_oe    = oe_q;
  assign buffer_address = ba_q;
  assign local_addr     = la_q;
  assign wr_data        = wd_q;
  assign wr_strobe      = wr_stb_q;
  assign rd_strobe      = rd_stb_q;
  assign rd_timeout     = to_q;
  assign dbg_state_o    = state_q;

endmodule
